// File: rtl/calc_arbiter.sv
// calc_arbiter
//   Shares one external datapath among NUM_REQ requesters with round-robin
//   arbitration and issues at most one operation per cycle. The granted
//   requester's operands are registered onto dp_a/dp_b/dp_c. A tag pipeline
//   carries {valid, id} alongside the datapath, so each response comes back
//   tagged with the requester that issued it.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   enable                  1 = grants allowed, 0 = issue paused
//   req_valid[NUM_REQ]      per-requester operation valid
//   req_ready[NUM_REQ]      combinational one-hot grant
//   req_a/req_b/req_c       flattened operands, requester i at [i*WIDTH +: WIDTH]
//   dp_a/dp_b/dp_c          registered operands to the shared datapath
//   dp_result               datapath result, valid LATENCY cycles after load
//   resp_valid/id/data      one-cycle response strobe, requester id, result
//   issue_count             saturating count of accepted operations
module calc_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  output logic [WIDTH-1:0]         dp_a,
  output logic [WIDTH-1:0]         dp_b,
  output logic [WIDTH-1:0]         dp_c,
  input  logic [WIDTH-1:0]         dp_result,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_data,
  output logic [15:0]              issue_count
);

  // Unflattened operand views, one entry per requester.
  logic [WIDTH-1:0] w_a [NUM_REQ];
  logic [WIDTH-1:0] w_b [NUM_REQ];
  logic [WIDTH-1:0] w_c [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a[gi] = req_a[gi*WIDTH +: WIDTH];
    assign w_b[gi] = req_b[gi*WIDTH +: WIDTH];
    assign w_c[gi] = req_c[gi*WIDTH +: WIDTH];
  end

  logic [ID_W-1:0]    r_rr_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_found;
  logic               w_fire;

  // Round-robin search starting at r_rr_ptr and wrapping. rst_n gates the
  // grant so nothing is offered while reset is held.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    w_grant    = '0;
    w_grant_id = '0;
    w_found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [ID_W-1:0] idx;
      // NOTE: blocking assignments here because idx and w_found are
      // consumed later in the same evaluation; clocked state uses <= only.
      idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[idx]) begin
        w_found    = 1'b1;
        w_grant_id = idx;
      end
    end
    if (enable && rst_n && w_found) begin
      w_grant[w_grant_id] = 1'b1;
    end
  end

  assign w_fire    = |w_grant;
  assign req_ready = w_grant;

  // Issue stage: operands plus the tag that travels with them.
  logic [WIDTH-1:0] r_dp_a, r_dp_b, r_dp_c;
  logic             r_issue_v;
  logic [ID_W-1:0]  r_issue_id;
  logic [15:0]      r_issue_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= '0;
      r_dp_a        <= '0;
      r_dp_b        <= '0;
      r_dp_c        <= '0;
      r_issue_v     <= 1'b0;
      r_issue_id    <= '0;
      r_issue_count <= '0;
    end else begin
      r_issue_v  <= w_fire;
      r_issue_id <= w_grant_id;
      if (w_fire) begin
        r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
        // Operands only move on a transfer so the datapath sees no idle toggling.
        r_dp_a   <= w_a[w_grant_id];
        r_dp_b   <= w_b[w_grant_id];
        r_dp_c   <= w_c[w_grant_id];
        if (r_issue_count != 16'hFFFF) begin
          r_issue_count <= r_issue_count + 16'd1;
        end
      end
    end
  end

  // Tag pipeline: LATENCY stages that line up with the datapath, so the last
  // stage is valid exactly when dp_result belongs to that issue.
  logic [LATENCY-1:0] r_tag_v;
  logic [ID_W-1:0]    r_tag_id [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      // NOTE: the id array is only a few flops, so it is reset with the valids
      // to keep resp_id deterministic; a wide payload array would be left unreset.
      for (int s = 0; s < LATENCY; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_v[0]  <= r_issue_v;
      r_tag_id[0] <= r_issue_id;
      for (int s = 1; s < LATENCY; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // Response register: strobe for one cycle, data and id hold otherwise.
  logic             r_resp_valid;
  logic [ID_W-1:0]  r_resp_id;
  logic [WIDTH-1:0] r_resp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= r_tag_v[LATENCY-1];
      if (r_tag_v[LATENCY-1]) begin
        r_resp_id   <= r_tag_id[LATENCY-1];
        r_resp_data <= dp_result;
      end
    end
  end

  assign dp_a        = r_dp_a;
  assign dp_b        = r_dp_b;
  assign dp_c        = r_dp_c;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_data   = r_resp_data;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter
//   Drives calc_arbiter (NUM_REQ=4, WIDTH=32, LATENCY=1) with directed and
//   random traffic. A small external datapath computes a*b+c with LATENCY
//   register stages. The reference model tracks the round-robin pointer as an
//   integer, keeps expected responses in a queue keyed by due edge, and
//   compares grants, operands, responses and the issue counter every cycle.
module tb_calc_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 1;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b, req_c;
  logic [W-1:0]   dp_a, dp_b, dp_c, dp_result;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_data;
  logic [15:0]    issue_count;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic [W-1:0] op_c [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_a[gi*W +: W] = op_a[gi];
    assign req_b[gi*W +: W] = op_b[gi];
    assign req_c[gi*W +: W] = op_c[gi];
  end

  calc_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_c       (dp_c),
    .dp_result  (dp_result),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External datapath: a*b+c through LAT register stages.
  logic [W-1:0] dp_pipe [LAT];
  always_ff @(posedge clk) begin
    dp_pipe[0] <= dp_a * dp_b + dp_c;
    for (int s = 1; s < LAT; s++) dp_pipe[s] <= dp_pipe[s-1];
  end
  assign dp_result = dp_pipe[LAT-1];

  // Reference model state.
  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] data;
  } resp_t;

  resp_t        exp_q[$];
  int           m_ptr;
  int           m_cnt;
  int           edge_n;
  int           last_grant;
  logic [W-1:0] m_a, m_b, m_c, m_rdata;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr      = 0;
    m_cnt      = 0;
    last_grant = -1;
    m_a        = '0;
    m_b        = '0;
    m_c        = '0;
    m_rdata    = '0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    int           g;
    logic [N-1:0] exp_ready;
    logic         exp_rv;
    #1;
    g = -1;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", W'(req_ready), W'(exp_ready));

    @(posedge clk);
    edge_n++;
    last_grant = g;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (m_cnt < 16'hFFFF) m_cnt++;
      m_a = op_a[g];
      m_b = op_b[g];
      m_c = op_c[g];
      exp_q.push_back('{due: edge_n + LAT + 1, id: g, data: m_a * m_b + m_c});
    end
    #1;
    check("dp_a", dp_a, m_a);
    check("dp_b", dp_b, m_b);
    check("dp_c", dp_c, m_c);
    check("issue_count", W'(issue_count), W'(m_cnt));
    exp_rv = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      exp_rv  = 1'b1;
      m_rdata = exp_q[0].data;
      check("resp_id", W'(resp_id), W'(exp_q[0].id));
      void'(exp_q.pop_front());
    end
    check("resp_valid", W'(resp_valid), W'(exp_rv));
    check("resp_data", resp_data, m_rdata);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", W'(req_ready), '0);
    check("rst_dp_a", dp_a, '0);
    check("rst_dp_b", dp_b, '0);
    check("rst_dp_c", dp_c, '0);
    check("rst_resp_valid", W'(resp_valid), '0);
    check("rst_resp_id", W'(resp_id), '0);
    check("rst_resp_data", resp_data, '0);
    check("rst_issue_count", W'(issue_count), '0);
  endtask

  // Asserts reset mid-cycle, checks the immediate clear, releases at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c);
    op_a[i] = a;
    op_b[i] = b;
    op_c[i] = c;
  endtask

  task automatic drain();
    req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) step();
    check("drain_queue_empty", W'(exp_q.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    edge_n    = 0;
    rst_n     = 1'b1;
    enable    = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_op(i, W'(i + 1), W'(i + 2), W'(i + 3));
    model_reset();
    #2;
    do_reset();

    // Single request from requester 2.
    req_valid = 4'b0100;
    set_op(2, 200, 4, 15);
    step();
    req_valid = '0;
    drain();
    check("single_result", m_rdata, 32'd815);

    // All four valid for 8 cycles from reset: grants rotate 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(10 * i + 1), W'(i + 5), W'(i));
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rotate_grant", W'(last_grant), W'(i % N));
    end
    drain();
    check("rotate_count", W'(issue_count), 32'd8);

    // Pointer at 2 with requesters 1 and 3 valid: grants 3, 1, 3.
    do_reset();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1010;
    set_op(1, 7, 8, 9);
    set_op(3, 3, 5, 1);
    step();
    check("sparse_g0", W'(last_grant), 32'd3);
    step();
    check("sparse_g1", W'(last_grant), 32'd1);
    step();
    check("sparse_g2", W'(last_grant), 32'd3);
    drain();

    // Issue one op, then pause with everything valid; in-flight op responds.
    req_valid = 4'b0001;
    set_op(0, 11, 12, 13);
    step();
    enable    = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 5; i++) step();
    enable = 1'b1;
    drain();

    // Reset one cycle after issuing id 1: nothing comes back, next grant is 0.
    do_reset();
    req_valid = 4'b0010;
    set_op(1, 21, 22, 23);
    step();
    req_valid = '0;
    do_reset();
    for (int i = 0; i < LAT + 3; i++) step();
    req_valid = '1;
    step();
    check("post_reset_grant", W'(last_grant), 32'd0);
    drain();

    // Random traffic; operands only change when not waiting for a grant.
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_grant == i) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_op(i, $urandom, $urandom, $urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      enable = ($urandom_range(0, 7) != 0);
      step();
    end
    enable = 1'b1;
    drain();

    // Counter saturation from 0xFFFE.
    do_reset();
    enable    = 1'b0;
    req_valid = '0;
    step();
    force dut.r_issue_count = 16'hFFFE;
    #1;
    release dut.r_issue_count;
    m_cnt = 16'hFFFE;
    check("sat_preload", W'(issue_count), 32'hFFFE);
    enable    = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 3; i++) step();
    check("sat_max", W'(issue_count), 32'hFFFF);
    step();
    drain();
    check("sat_hold", W'(issue_count), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
